// File: rtl/nn_pkg.sv
// Shared constants and word type for the image input stage and the neuron/layer blocks.
package nn_pkg;

    localparam int NN_WORD_W     = 32;
    localparam int NN_NUM_PIXELS = 784;

    typedef logic [NN_WORD_W-1:0] word_t;

endpackage : nn_pkg

// File: rtl/frame_bank.sv
// One frame of pixel words: indexed single-word write port, whole frame visible as a flat vector.
module frame_bank
    import nn_pkg::*;
#(
    parameter int NUM_PIXELS = NN_NUM_PIXELS,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic                            clk,
    input  logic                            wr_en_i,
    input  logic [IDX_W-1:0]                wr_idx_i,
    input  word_t                           wr_data_i,
    output logic [NUM_PIXELS*NN_WORD_W-1:0] rd_frame_o
);

    word_t mem_q [NUM_PIXELS];

    // NOTE: the array has no reset on purpose; a bank's contents are only
    // observed once the full flag says it holds a complete frame.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_rd
        assign rd_frame_o[NN_WORD_W*i +: NN_WORD_W] = mem_q[i];
    end

endmodule : frame_bank

// File: rtl/image_frame_buffer.sv
// Ping-pong pixel-to-frame buffer: assembles serial pixels into one of two banks and
// presents each completed frame until the consumer acknowledges it.
module image_frame_buffer
    import nn_pkg::*;
#(
    parameter int NUM_PIXELS = NN_NUM_PIXELS,
    parameter int PIXEL_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [PIXEL_W-1:0]              s_pixel,
    input  logic                            s_last,
    output logic                            out_valid,
    input  logic                            out_ack,
    output logic [NUM_PIXELS*NN_WORD_W-1:0] out_frame,
    output logic                            err_framing,
    output logic [CNT_W-1:0]                frames_done
);

    localparam int              IDX_W    = $clog2(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             err_q, err_d;

    logic  accept;
    logic  at_last;
    logic  release_frame;
    word_t pixel_word;
    logic [NUM_PIXELS*NN_WORD_W-1:0] frame0, frame1;

    // Readiness looks only at registered flags, so out_ack never reaches s_ready combinationally.
    assign s_ready       = !full_q[wr_bank_q];
    assign out_valid     = full_q[rd_bank_q];
    assign accept        = s_valid && s_ready;
    assign at_last       = (wr_idx_q == LAST_IDX);
    assign release_frame = out_ack && out_valid;
    assign pixel_word    = {{(NN_WORD_W-PIXEL_W){1'b0}}, s_pixel};

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        frames_d  = frames_q;
        err_d     = 1'b0;

        if (release_frame) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        // A commit only targets a non-full bank and a release only a full one, so they never collide.
        if (accept) begin
            err_d = s_last ^ at_last;
            if (at_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
                frames_d          = frames_q + CNT_W'(1);
            end else if (s_last) begin
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            frames_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            frames_q  <= frames_d;
            err_q     <= err_d;
        end
    end

    assign err_framing = err_q;
    assign frames_done = frames_q;

    frame_bank #(
        .NUM_PIXELS (NUM_PIXELS),
        .IDX_W      (IDX_W)
    ) u_bank0 (
        .clk        (clk),
        .wr_en_i    (accept && !wr_bank_q),
        .wr_idx_i   (wr_idx_q),
        .wr_data_i  (pixel_word),
        .rd_frame_o (frame0)
    );

    frame_bank #(
        .NUM_PIXELS (NUM_PIXELS),
        .IDX_W      (IDX_W)
    ) u_bank1 (
        .clk        (clk),
        .wr_en_i    (accept && wr_bank_q),
        .wr_idx_i   (wr_idx_q),
        .wr_data_i  (pixel_word),
        .rd_frame_o (frame1)
    );

    assign out_frame = rd_bank_q ? frame1 : frame0;

endmodule : image_frame_buffer

// File: tb/tb_image_frame_buffer.sv
// Self-checking bench for image_frame_buffer: frame-queue reference model plus directed scenarios.
module tb_image_frame_buffer;

    localparam int N     = 784;
    localparam int PW    = 8;
    localparam int CW    = 16;
    localparam int FW    = N * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_pixel;
    logic          s_last;
    logic          out_valid;
    logic          out_ack;
    logic [FW-1:0] out_frame;
    logic          err_framing;
    logic [CW-1:0] frames_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit cmp_en   = 1'b0;

    image_frame_buffer #(
        .NUM_PIXELS (N),
        .PIXEL_W    (PW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_pixel     (s_pixel),
        .s_last      (s_last),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .out_frame   (out_frame),
        .err_framing (err_framing),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: frames waiting for the consumer, the partial frame, counters.
    logic [FW-1:0] m_q [$];
    logic [7:0]    m_cur [N];
    int            m_idx;
    int            m_frames;
    bit            m_err;

    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = {24'b0, m_cur[i]};
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit acc, ack;
        if (!rst_n) begin
            m_q.delete();
            m_idx    = 0;
            m_frames = 0;
            m_err    = 1'b0;
        end else begin
            acc   = s_valid && (m_q.size() < 2);
            ack   = out_ack && (m_q.size() > 0);
            m_err = 1'b0;
            if (ack) void'(m_q.pop_front());
            if (acc) begin
                m_cur[m_idx] = s_pixel;
                if (m_idx == N - 1) begin
                    m_q.push_back(pack_frame());
                    m_frames = (m_frames + 1) % (1 << CW);
                    m_idx    = 0;
                    m_err    = !s_last;
                end else if (s_last) begin
                    m_err = 1'b1;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [FW-1:0] exp_f;
        int k;
        if (rst_n && cmp_en) begin
            check("s_ready", 64'(s_ready), 64'(m_q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("err_framing", 64'(err_framing), 64'(m_err));
            check("frames_done", 64'(frames_done), 64'(m_frames));
            if (m_q.size() > 0) begin
                exp_f = m_q[0];
                k = 0;
                if (out_frame !== exp_f) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (out_frame[32*i +: 32] !== exp_f[32*i +: 32]) k = i;
                end
                check($sformatf("out_frame_word%0d", k), 64'(out_frame[32*k +: 32]), 64'(exp_f[32*k +: 32]));
            end
        end
    end

    function automatic logic [7:0] pix_of(input int mode, input int i);
        case (mode)
            0:       return 8'(i % 256);
            1:       return 8'((i + 7) % 256);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ack_mode: 0 none, 1 random, 2 single ack at cycle ack_at, 3 ack on the final beat.
    task automatic drive_frame(input int n, input int last_at, input int mode,
                               input int ack_mode, input int ack_at, input int gap_pct);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n) begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_pixel = pix_of(mode, i);
            s_last  = (i == last_at);
            case (ack_mode)
                1:       out_ack = ($urandom_range(0, 3) == 0);
                2:       out_ack = (cyc == ack_at);
                3:       out_ack = (i == n - 1) && s_valid;
                default: out_ack = 1'b0;
            endcase
            acc = s_valid && s_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
            if (cyc > 20 * N) begin
                chk_cnt++;
                $display("FAIL beat_timeout: %0d beats accepted of %0d after %0d cycles", i, n, cyc);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        out_ack = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (out_valid) begin
            out_ack = 1'b1;
            @(negedge clk);
            cyc++;
            if (cyc > 8) begin
                chk_cnt++;
                $display("FAIL drain_timeout: out_valid still %0b after %0d acks", out_valid, cyc);
                break;
            end
        end
        out_ack = 1'b0;
    endtask

    initial begin
        int r, last_at, n;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_pixel = '0;
        s_last  = 1'b0;
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err_framing), 64'd0);
        check("rst_frames", 64'(frames_done), 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single frame of pattern i mod 256.
        drive_frame(N, N - 1, 0, 0, 0, 0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_w300", 64'(out_frame[32*300 +: 32]), 64'h0000_002C);
        check("single_w783", 64'(out_frame[32*783 +: 32]), 64'h0000_000F);
        check("single_frames", 64'(frames_done), 64'd1);
        check("single_err", 64'(err_framing), 64'd0);

        // Bank 1 completes on the same edge bank 0 is acknowledged.
        drive_frame(N, N - 1, 1, 3, 0, 0);
        check("swap_valid", 64'(out_valid), 64'd1);
        check("swap_w0", 64'(out_frame[31:0]), 64'h0000_0007);
        check("swap_w300", 64'(out_frame[32*300 +: 32]), 64'h0000_0033);
        check("swap_frames", 64'(frames_done), 64'd2);

        // Back-pressure: two frames fill both banks, the third waits for one ack.
        drain();
        drive_frame(N, N - 1, 2, 0, 0, 0);
        check("bp_ready_after1", 64'(s_ready), 64'd1);
        drive_frame(N, N - 1, 2, 0, 0, 0);
        check("bp_ready_after2", 64'(s_ready), 64'd0);
        check("bp_frames2", 64'(frames_done), 64'd4);
        drive_frame(N, N - 1, 2, 2, 5, 0);
        check("bp_frames3", 64'(frames_done), 64'd5);
        check("bp_ready_after3", 64'(s_ready), 64'd0);

        // Early s_last at index 99, then a clean frame.
        drain();
        drive_frame(100, 99, 2, 0, 0, 0);
        check("early_err", 64'(err_framing), 64'd1);
        check("early_frames", 64'(frames_done), 64'd5);
        check("early_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("early_err_pulse", 64'(err_framing), 64'd0);
        drive_frame(N, N - 1, 2, 0, 0, 0);
        check("clean_err", 64'(err_framing), 64'd0);
        check("clean_frames", 64'(frames_done), 64'd6);

        // Missing s_last on the final pixel still commits.
        drain();
        drive_frame(N, -1, 2, 0, 0, 0);
        check("miss_err", 64'(err_framing), 64'd1);
        check("miss_valid", 64'(out_valid), 64'd1);
        check("miss_frames", 64'(frames_done), 64'd7);

        // Randomized traffic with gaps, random acks and random framing faults.
        for (int f = 0; f < 6; f++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      last_at = int'($urandom_range(0, N - 2));
            else if (r == 1) last_at = -1;
            else             last_at = N - 1;
            n = (last_at >= 0 && last_at < N - 1) ? last_at + 1 : N;
            drive_frame(n, last_at, 2, 1, 0, 20);
        end

        // Asynchronous reset mid-frame with one frame pending.
        drain();
        drive_frame(N, N - 1, 2, 0, 0, 0);
        drive_frame(400, -1, 2, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_s_ready", 64'(s_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_err", 64'(err_framing), 64'd0);
        check("arst_frames", 64'(frames_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_frame(N, N - 1, 0, 0, 0, 0);
        check("post_rst_frames", 64'(frames_done), 64'd1);
        check("post_rst_w300", 64'(out_frame[32*300 +: 32]), 64'h0000_002C);
        check("post_rst_valid", 64'(out_valid), 64'd1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_image_frame_buffer

// File: doc/image_frame_buffer.md
# image_frame_buffer

Ping-pong input stage directly upstream of the first hidden layer. It accepts a serial stream of 8-bit image pixels over a valid/ready handshake and zero-extends each pixel to a 32-bit word. It assembles each image into a flat `NUM_PIXELS*32`-bit frame vector and presents a completed frame to the layer's `inputs` bus, holding it stable until the consumer acknowledges. Two banks allow the next image to load while the current one is being consumed.

## Interface
- `NUM_PIXELS`, 784, pixels per frame (≥2).
- `PIXEL_W`, 8, input pixel width; zero-extended to 32 bits.
- `CNT_W`, 16, width of the frame counter.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  pixel beat valid.
- `s_ready`  out  1  buffer can accept a beat.
- `s_pixel`  in  PIXEL_W  pixel value.
- `s_last`  in  1  marks the final pixel of an image.
- `out_valid`  out  1  `out_frame` holds a complete frame.
- `out_ack`  in  1  consumer releases the presented frame.
- `out_frame`  out  NUM_PIXELS*32  pixel i at bits `[32*i+31:32*i]`.
- `err_framing`  out  1  one-cycle pulse on an `s_last` mismatch.
- `frames_done`  out  CNT_W  count of committed frames; wraps.

## Operation
- State per bank: `full[b]`. Pointers `wr_bank`, `rd_bank` (1 bit each). Pixel index `wr_idx` runs 0..NUM_PIXELS-1.
- Beat accepted when `s_valid && s_ready`:
  - Write `{24'b0, s_pixel}` (generally `32-PIXEL_W` zeros) into word `wr_idx` of `wr_bank`.
- Index handling on an accepted beat:
  - `wr_idx == NUM_PIXELS-1`: commit. Set `full[wr_bank]`, toggle `wr_bank`, clear `wr_idx`, increment `frames_done`.
  - Otherwise: increment `wr_idx`.
- Framing errors. The frame length is fixed by `NUM_PIXELS`, not by `s_last`.
  - `s_last=1` at index < NUM_PIXELS-1: pulse `err_framing`, discard the partial frame, clear `wr_idx`. The bank stays not full and no commit occurs.
  - `s_last=0` at index NUM_PIXELS-1: pulse `err_framing` and commit the frame normally.
- `s_ready = !full[wr_bank]`. It depends on registered state only, with no combinational path from `out_ack`.
- `out_valid = full[rd_bank]`. `out_frame` is the register contents of `rd_bank`, muxed. It is stable while `out_valid` is high.
- `out_ack && out_valid`: clear `full[rd_bank]`, toggle `rd_bank`. `out_ack` while `out_valid` is low is ignored.
- Commit and ack in the same cycle act on different banks; both take effect.
- Both banks full: `s_ready` is low. It rises in the cycle after the ack.
- Bank storage is not cleared on reset or on release. The contents are don't-care while the bank is not full.

## Timing
- Reset values: `s_ready=1`, `out_valid=0`, `err_framing=0`, `frames_done=0`, `wr_idx=0`, `wr_bank=rd_bank=0`, `full=2'b00`.
- Reset mid-frame discards the partial frame and any unconsumed frames.
- Latency: if the last beat is accepted at edge k, `out_valid` is high from the cycle after edge k (when that bank is `rd_bank`).
- Ack accepted at edge k: `out_valid` drops after edge k, or stays high with the other bank's frame if that bank is full.
- `err_framing` is high for exactly the one cycle following the offending beat.
- Throughput: one pixel per cycle sustained, provided the consumer acks each frame within NUM_PIXELS cycles.

## Structure
- Shared package `nn_pkg`: constants `NN_WORD_W=32`, `NN_NUM_PIXELS=784`, and a `word_t` typedef. The neuron and layer blocks use the same package.
- Sub-module `frame_bank`: NUM_PIXELS×32 register array with a write enable, a write index, a 32-bit write data port and a flat full-width read output. It is instantiated twice.
- The top level holds the pointers, `full` flags, index counter, error logic and frame counter.

## Test plan
- Single frame: pixel i = i mod 256 for 784 beats with `s_last` on the final beat. Expect `out_valid` 1 cycle after the last beat, word 300 = 32'h0000_002C, `frames_done=1`, no error.
- Back-pressure: send three frames with no ack. Expect `s_ready=0` after the 2nd commit. Ack once: `s_ready=1` next cycle, and the 3rd frame loads into the freed bank.
- Early `s_last` at index 99: `err_framing` pulses once, `frames_done` is unchanged, and the next 784-beat frame commits cleanly.
- Missing `s_last` at index 783: `err_framing` pulses and the frame still commits with `out_valid=1`.
- Commit and ack in the same cycle, with bank 0 presented and bank 1 completing. Expect `out_valid` to stay high and `out_frame` to switch to bank 1's data.
- Assert `rst_n` low at pixel 400 with one frame pending. All outputs return to reset values asynchronously and `out_valid=0`.
